// File: rtl/mp_alu_driver.sv
// Multi-byte ALU sequencer: feeds an external 8-bit combinational ALU one byte per cycle, LSB first.
// Optional rsp_zero output is built when MP_ALU_ZERO_FLAG_EN is defined.
module mp_alu_driver #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [8*NBYTES-1:0] req_a,
  input  logic [8*NBYTES-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [8*NBYTES-1:0] rsp_sum,
  output logic                rsp_carry,
`ifdef MP_ALU_ZERO_FLAG_EN
  output logic                rsp_zero,
`endif
  output logic [80:0]         alu_oper,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic                alu_c_in,
  input  logic [7:0]          alu_sum,
  input  logic                alu_c_out
);

  localparam int DATA_W = 8 * NBYTES;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [DATA_W-1:0]   sum_q;
  logic                carry_q;
  logic [IDX_W-1:0]    idx_q;
  logic                accept;
  logic                last_byte;

  // ALU operation names, right-justified and zero-padded to 81 bits
  function automatic logic [80:0] op_name(input logic [2:0] op);
    case (op)
      3'd0:    op_name = {57'd0, "and"};
      3'd1:    op_name = {17'd0, "abstract"};
      3'd2:    op_name = {1'b0,  "abstract_a"};
      3'd3:    op_name = {41'd0, "or_ab"};
      3'd4:    op_name = {33'd0, "and_ab"};
      3'd5:    op_name = {33'd0, "not_ab"};
      3'd6:    op_name = {49'd0, "exor"};
      default: op_name = {41'd0, "exnor"};
    endcase
  endfunction

  assign accept    = req_valid && (state_q == IDLE);
  assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ISSUE;
      ISSUE:   if (last_byte) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage: request latch and per-byte result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 3'd0;
      idx_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      op_q  <= req_op;
      idx_q <= '0;
    end else if (state_q == ISSUE) begin
      for (int i = 0; i < NBYTES; i++)
        if (idx_q == IDX_W'(i)) sum_q[8*i +: 8] <= alu_sum;
      carry_q <= (op_q <= 3'd2) ? alu_c_out : 1'b0;
      idx_q   <= last_byte ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= req_a;
      b_q <= req_b;
    end
  end

  // Stage: ALU drive and handshake outputs
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = 8'd0;
    alu_b     = 8'd0;
    alu_c_in  = 1'b0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      ISSUE: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            alu_a = a_q[8*i +: 8];
            alu_b = b_q[8*i +: 8];
          end
        end
        // RSUB's ALU takes a borrow, so the no-borrow carry is inverted on the way back in
        if (idx_q == '0)
          alu_c_in = (op_q == 3'd1);
        else if (op_q == 3'd0 || op_q == 3'd1)
          alu_c_in = carry_q;
        else if (op_q == 3'd2)
          alu_c_in = ~carry_q;
      end
      RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign alu_oper  = op_name(op_q);
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;

`ifdef MP_ALU_ZERO_FLAG_EN
  assign rsp_zero = rsp_valid && (sum_q == '0);
`endif

endmodule

// File: tb/tb_mp_alu_driver.sv
// Bench for mp_alu_driver: behavioural byte ALU, full-width arithmetic reference, directed and random ops.
// Checks rsp_zero as well when MP_ALU_ZERO_FLAG_EN is defined.
module tb_mp_alu_driver;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  localparam logic [80:0] S_ADD  = {57'd0, "and"};
  localparam logic [80:0] S_SUB  = {17'd0, "abstract"};
  localparam logic [80:0] S_RSUB = {1'b0,  "abstract_a"};
  localparam logic [80:0] S_OR   = {41'd0, "or_ab"};
  localparam logic [80:0] S_AND  = {33'd0, "and_ab"};
  localparam logic [80:0] S_ANDN = {33'd0, "not_ab"};
  localparam logic [80:0] S_XOR  = {49'd0, "exor"};
  localparam logic [80:0] S_XNOR = {41'd0, "exnor"};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, rsp_valid, rsp_ready, rsp_carry;
  logic [2:0]   req_op;
  logic [W-1:0] req_a, req_b, rsp_sum;
  logic [80:0]  alu_oper;
  logic [7:0]   alu_a, alu_b, alu_sum;
  logic         alu_c_in, alu_c_out;
`ifdef MP_ALU_ZERO_FLAG_EN
  logic         rsp_zero;
`endif

  int total = 0;
  int bad   = 0;
  logic [W-1:0] last_sum;

  mp_alu_driver #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
`ifdef MP_ALU_ZERO_FLAG_EN
    .rsp_zero(rsp_zero),
`endif
    .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in),
    .alu_sum(alu_sum), .alu_c_out(alu_c_out)
  );

  always #5 clk = ~clk;

  // Combinational byte ALU; the RSUB flavour subtracts a borrow-in and reports carry as "no borrow"
  always_comb begin
    logic [8:0] t;
    t = 9'd0;
    case (alu_oper)
      S_ADD:  t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c_in};
      S_SUB:  t = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_c_in};
      S_RSUB: begin
        t = {1'b0, alu_b} - {1'b0, alu_a} - {8'd0, alu_c_in};
        t[8] = ~t[8];
      end
      S_OR:   t = {1'b0, alu_a | alu_b};
      S_AND:  t = {1'b0, alu_a & alu_b};
      S_ANDN: t = {1'b0, ~alu_a & alu_b};
      S_XOR:  t = {1'b0, alu_a ^ alu_b};
      S_XNOR: t = {1'b0, ~(alu_a ^ alu_b)};
      default: t = 9'd0;
    endcase
    alu_sum   = t[7:0];
    alu_c_out = t[8];
  end

  function automatic logic [80:0] name_of(input logic [2:0] op);
    logic [80:0] tbl [8];
    tbl = '{S_ADD, S_SUB, S_RSUB, S_OR, S_AND, S_ANDN, S_XOR, S_XNOR};
    return tbl[op];
  endfunction

  // Full-width reference: result, final carry (no-borrow for subtracts)
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] s, output logic c);
    logic [W:0] t;
    c = 1'b0;
    case (op)
      3'd0: begin t = {1'b0, a} + {1'b0, b}; s = t[W-1:0]; c = t[W]; end
      3'd1: begin s = a - b; c = (a >= b); end
      3'd2: begin s = b - a; c = (b >= a); end
      3'd3: s = a | b;
      3'd4: s = a & b;
      3'd5: s = ~a & b;
      3'd6: s = a ^ b;
      default: s = ~(a ^ b);
    endcase
  endtask

  // Expected carry-in per byte, from the arithmetic on the lower i bytes only
  function automatic logic [NB-1:0] exp_cin(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W:0]   m, al, bl, t;
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      m  = ((W+1)'(1) << (8 * i)) - 1;
      al = {1'b0, a} & m;
      bl = {1'b0, b} & m;
      t  = al + bl;
      case (op)
        3'd0: r[i] = t[8*i];
        3'd1: r[i] = (al >= bl);
        3'd2: r[i] = (bl < al);
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input string tag);
    logic [W-1:0]  es, s0;
    logic          ec, c0;
    logic [NB-1:0] cins;
    int            lat;
    model(op, a, b, es, ec);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_a = $urandom; req_b = $urandom;
    lat = 0; cins = '0;
    while (!rsp_valid && lat < 4 * NB + 8) begin
      if (lat < NB) cins[lat] = alu_c_in;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, NB);
    chk({tag, ".sum"}, rsp_sum, es);
    chk({tag, ".carry"}, rsp_carry, ec);
    chk({tag, ".cin_seq"}, cins, exp_cin(op, a, b));
    chk({tag, ".oper"}, alu_oper, name_of(op));
    chk({tag, ".alu_idle"}, {alu_a, alu_b, alu_c_in}, 17'd0);
`ifdef MP_ALU_ZERO_FLAG_EN
    chk({tag, ".zero"}, rsp_zero, (es == '0));
`endif
    s0 = rsp_sum; c0 = rsp_carry;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'($urandom); req_a = $urandom; req_b = $urandom;
      @(posedge clk); #1;
      chk({tag, ".hold"}, {rsp_valid, req_ready, rsp_carry, rsp_sum, alu_oper},
          {1'b1, 1'b0, c0, s0, name_of(op)});
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".after_hs"}, {rsp_valid, req_ready}, 2'b01);
    rsp_ready = 1'b0;
    last_sum = es;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset.ctl", {req_ready, rsp_valid, rsp_carry}, 3'b100);
    chk("reset.sum", rsp_sum, 0);
    chk("reset.oper", alu_oper, S_ADD);
    chk("reset.alu", {alu_a, alu_b, alu_c_in}, 17'd0);

    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0, "add_wrap");
    run_op(3'd1, 32'd5, 32'd7, 1, "sub_borrow");
    run_op(3'd1, 32'd7, 32'd5, 0, "sub_ok");
    run_op(3'd2, 32'd7, 32'd5, 2, "rsub");
    run_op(3'd6, 32'h1234_5678, 32'hFFFF_0000, 10, "xor_hold");

    // rsp_ready with nothing pending must not disturb the last result
    @(negedge clk); rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ready.sum", rsp_sum, last_sum);
    chk("idle_ready.valid", rsp_valid, 1'b0);
    @(negedge clk); rsp_ready = 1'b0;

    // Idle reset after a non-zero op returns the op name to "and"
    #1 rst_n = 1'b0;
    #1 chk("idle_rst.oper", alu_oper, S_ADD);
    @(negedge clk); rst_n = 1'b1;

    // Reset while byte 2 of an ADD is on the ALU
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'hAABB_CCDD; req_b = 32'h1122_3344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid.byte2", {alu_a, alu_b}, 16'hBB22);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.out", {rsp_valid, rsp_carry, alu_a, alu_b, alu_c_in}, 19'd0);
    chk("mid_rst.sum", rsp_sum, 0);
    chk("mid_rst.oper", alu_oper, S_ADD);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("mid_rst.no_rsp", {rsp_valid, req_ready}, 2'b01);
    end
    run_op(3'd0, 32'h0000_00FF, 32'h0000_0001, 0, "post_rst_add");

    for (int n = 0; n < 24; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (n % 5 == 0) ? ra : $urandom;
      run_op(rop, ra, rb, $urandom_range(0, 3), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
